// File: rtl/alu_result_buffer.sv
// ALU result buffer: captures ALU results into a small FWFT FIFO
// toward writeback, and tracks the status word and sticky overflow.
module alu_result_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] alu_out0,
    input  logic          alu_c,
    input  logic          alu_v,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic [3:0]    alu_op,
    input  logic [3:0]    alu_op1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] res_lo,
    output logic [DW-1:0] res_hi,
    output logic [3:0]    res_flags,
    output logic [7:0]    res_tag,
    output logic [3:0]    psw,
    output logic          sticky_v,
    input  logic          clr_sticky,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] mem_lo    [DEPTH];
    logic [DW-1:0] mem_hi    [DEPTH];
    logic [3:0]    mem_flags [DEPTH];
    logic [7:0]    mem_tag   [DEPTH];

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   cnt;

    logic          push;
    logic          pop;
    logic          mask_vc;
    logic          take_hi;
    logic [DW-1:0] new_hi;
    logic [3:0]    new_flags;

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    assign res_lo    = mem_lo[rptr];
    assign res_hi    = mem_hi[rptr];
    assign res_flags = mem_flags[rptr];
    assign res_tag   = mem_tag[rptr];

    // Decode op class: shift/logic drop V and C, multiply keeps high word
    always_comb begin
        mask_vc = 1'b0;
        take_hi = 1'b0;
        unique case (alu_op)
            4'b0001, 4'b0010: mask_vc = 1'b1;
            4'b0011:          take_hi = 1'b1;
            default:          ;
        endcase
    end

    assign new_hi    = take_hi ? alu_out0 : '0;
    assign new_flags = {alu_n, alu_z, alu_v & ~mask_vc, alu_c & ~mask_vc};

    // Entry storage, written at wptr on push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_lo[i]    <= '0;
                mem_hi[i]    <= '0;
                mem_flags[i] <= '0;
                mem_tag[i]   <= '0;
            end
        end else if (push) begin
            mem_lo[wptr]    <= alu_out;
            mem_hi[wptr]    <= new_hi;
            mem_flags[wptr] <= new_flags;
            mem_tag[wptr]   <= {alu_op, alu_op1};
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            if (push && !pop)      cnt <= cnt + CNT_ONE;
            else if (pop && !push) cnt <= cnt - CNT_ONE;
        end
    end

    // Status word follows each accepted result; sticky set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psw      <= '0;
            sticky_v <= 1'b0;
        end else begin
            if (push) psw <= new_flags;
            if (push && new_flags[1]) sticky_v <= 1'b1;
            else if (clr_sticky)      sticky_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_alu_result_buffer;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;
        logic [7:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_out = '0;
    logic [31:0] alu_out0 = '0;
    logic        alu_c = 1'b0;
    logic        alu_v = 1'b0;
    logic        alu_z = 1'b0;
    logic        alu_n = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [3:0]  alu_op1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic [3:0]  res_flags;
    logic [7:0]  res_tag;
    logic [3:0]  psw;
    logic        sticky_v;
    logic        clr_sticky = 1'b0;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    ent_t        q[$];
    logic [3:0]  m_psw = '0;
    logic        m_sticky = 1'b0;
    int          cmp = 0;
    int          bad = 0;

    alu_result_buffer #(.DW(32), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_out0(alu_out0),
        .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
        .alu_op(alu_op), .alu_op1(alu_op1),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi),
        .res_flags(res_flags), .res_tag(res_tag),
        .psw(psw), .sticky_v(sticky_v), .clr_sticky(clr_sticky),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Expected entry straight from the op-class rules
    function automatic ent_t form();
        ent_t e;
        bit   logical;
        logical = (alu_op == 4'd1) || (alu_op == 4'd2);
        e.lo  = alu_out;
        e.hi  = (alu_op == 4'd3) ? alu_out0 : 32'd0;
        e.fl  = {alu_n, alu_z, logical ? 1'b0 : alu_v,
                 logical ? 1'b0 : alu_c};
        e.tag = {alu_op, alu_op1};
        return e;
    endfunction

    // Advance one clock, updating the model from pre-edge inputs
    task automatic step();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        @(posedge clk);
        do_push = in_valid && (q.size() < 4);
        do_pop  = out_ready && (q.size() > 0);
        e = form();
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(e);
            m_psw = e.fl;
        end
        if (do_push && e.fl[1]) m_sticky = 1'b1;
        else if (clr_sticky)    m_sticky = 1'b0;
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
    endtask

    task automatic rand_alu();
        alu_out  = $urandom;
        alu_out0 = $urandom;
        {alu_n, alu_z, alu_v, alu_c} = 4'($urandom);
        alu_op   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        alu_op1  = 4'($urandom);
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_psw = '0;
        m_sticky = 1'b0;
        cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        cmp++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        cmp++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_empty_full got %b%b want 10", empty, full); end
        cmp++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        cmp++; if ({res_lo, res_hi, res_flags, res_tag} !== 76'd0) begin bad++; $display("FAIL reset_res got %h %h %h %h want 0", res_lo, res_hi, res_flags, res_tag); end
        cmp++; if (psw !== 4'd0 || sticky_v !== 1'b0) begin bad++; $display("FAIL reset_psw_sticky got %b %b want 0000 0", psw, sticky_v); end
    endtask

    task automatic test_fill_drain();
        ent_t exp_e[4];
        idle();
        for (int i = 0; i < 4; i++) begin
            rand_alu();
            in_valid = 1'b1;
            exp_e[i] = form();
            step();
        end
        cmp++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d want 1 0 4", full, in_ready, count); end
        rand_alu();
        step();
        cmp++; if (count !== 3'd4) begin bad++; $display("FAIL fill_drop5 got cnt=%0d want 4", count); end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmp++;
            if (out_valid !== 1'b1 || {res_lo, res_hi, res_flags, res_tag} !== exp_e[i]) begin
                bad++;
                $display("FAIL drain_order[%0d] got v=%b %h %h %h %h want %h %h %h %h", i, out_valid, res_lo, res_hi, res_flags, res_tag, exp_e[i].lo, exp_e[i].hi, exp_e[i].fl, exp_e[i].tag);
            end
            step();
        end
        cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got empty=%b v=%b want 1 0", empty, out_valid); end
        idle();
    endtask

    task automatic test_add_flags();
        idle();
        alu_out = 32'hFFFE0000; alu_out0 = 32'h0;
        alu_op = 4'b0000; alu_op1 = 4'b0000;
        {alu_n, alu_z, alu_v, alu_c} = 4'b1010;
        in_valid = 1'b1;
        step();
        idle();
        cmp++; if (res_flags !== 4'b1010) begin bad++; $display("FAIL add_flags got %b want 1010", res_flags); end
        cmp++; if (psw !== 4'b1010) begin bad++; $display("FAIL add_psw got %b want 1010", psw); end
        cmp++; if (sticky_v !== 1'b1) begin bad++; $display("FAIL add_sticky got %b want 1", sticky_v); end
        clr_sticky = 1'b1;
        step();
        idle();
        cmp++; if (sticky_v !== 1'b0) begin bad++; $display("FAIL clr_sticky got %b want 0", sticky_v); end
        in_valid = 1'b1; clr_sticky = 1'b1;
        alu_op = 4'b0000; {alu_n, alu_z, alu_v, alu_c} = 4'b0010;
        step();
        idle();
        cmp++; if (sticky_v !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got %b want 1", sticky_v); end
        drain();
    endtask

    task automatic test_logic_mask();
        idle();
        alu_out = 32'h01010000; alu_out0 = 32'hDEADBEEF;
        alu_op = 4'b0010; alu_op1 = 4'b0010;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0011;
        in_valid = 1'b1;
        step();
        idle();
        cmp++; if (res_flags !== 4'b0000) begin bad++; $display("FAIL logic_flags got %b want 0000", res_flags); end
        cmp++; if (res_hi !== 32'h0 || res_lo !== 32'h01010000) begin bad++; $display("FAIL logic_words got %h %h want 00000000 01010000", res_hi, res_lo); end
        cmp++; if (res_tag !== 8'h22) begin bad++; $display("FAIL logic_tag got %h want 22", res_tag); end
        drain();
    endtask

    task automatic test_multiply();
        idle();
        alu_out = 32'h0; alu_out0 = 32'h00000002;
        alu_op = 4'b0011; alu_op1 = 4'b0000;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0100;
        in_valid = 1'b1;
        step();
        idle();
        cmp++; if (res_lo !== 32'h0 || res_hi !== 32'h2) begin bad++; $display("FAIL mul_words got %h %h want 00000000 00000002", res_lo, res_hi); end
        cmp++; if (res_flags !== 4'b0100) begin bad++; $display("FAIL mul_flags got %b want 0100", res_flags); end
        drain();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 2; i++) begin
            rand_alu(); in_valid = 1'b1; step();
        end
        cmp++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_prefill got %0d want 2", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rand_alu();
            step();
            cmp++;
            if (count !== 3'd2 || res_lo !== q[0].lo || res_tag !== q[0].tag) begin
                bad++;
                $display("FAIL b2b[%0d] got cnt=%0d lo=%h tag=%h want 2 %h %h", i, count, res_lo, res_tag, q[0].lo, q[0].tag);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        idle();
        for (int i = 0; i < 3; i++) begin
            rand_alu(); in_valid = 1'b1; step();
        end
        idle();
        #2 rst = 1'b1;
        #1;
        q.delete(); m_psw = '0; m_sticky = 1'b0;
        cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL async_rst got v=%b cnt=%0d want 0 0", out_valid, count); end
        cmp++; if (psw !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL async_rst_psw got psw=%b empty=%b want 0000 1", psw, empty); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_alu();
            in_valid   = 1'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            clr_sticky = ($urandom_range(0, 5) == 0);
            step();
            cmp++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== (q.size() < 4) || full !== (q.size() == 4) || empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL rand_occ[%0d] got cnt=%0d v=%b r=%b f=%b e=%b want cnt=%0d", i, count, out_valid, in_ready, full, empty, q.size());
            end
            cmp++;
            if (psw !== m_psw || sticky_v !== m_sticky) begin
                bad++;
                $display("FAIL rand_status[%0d] got %b %b want %b %b", i, psw, sticky_v, m_psw, m_sticky);
            end
            if (q.size() > 0) begin
                cmp++;
                if ({res_lo, res_hi, res_flags, res_tag} !== q[0]) begin
                    bad++;
                    $display("FAIL rand_head[%0d] got %h %h %h %h want %h %h %h %h", i, res_lo, res_hi, res_flags, res_tag, q[0].lo, q[0].hi, q[0].fl, q[0].tag);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_add_flags();
        test_logic_mask();
        test_multiply();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Writeback-side stage directly downstream of the 32-bit ALU.
- Captures each ALU result: `out`, `out0` (multiply high word), `carryout`, `overflow`, `zero`, `N`, plus the issuing `op`/`op1`.
- Queues results in a small FIFO with a valid/ready handshake toward the register-file writeback.
- Maintains an architectural status word (PSW) and a sticky overflow flag.

Parameters:
- DW, 32, data width of the result words.
- DEPTH, 4, FIFO entries (power of two).
- AW, 2, log2(DEPTH), pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  buffer can accept a result.
- alu_out  input  DW  ALU result, low word.
- alu_out0  input  DW  ALU multiply high word.
- alu_c  input  1  ALU carryout.
- alu_v  input  1  ALU overflow.
- alu_z  input  1  ALU zero.
- alu_n  input  1  ALU negative (N).
- alu_op  input  4  ALU op class (0000 arith, 0001 shift, 0010 logic, 0011 multiply).
- alu_op1  input  4  ALU sub-op.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes head.
- res_lo  output  DW  head low word.
- res_hi  output  DW  head high word.
- res_flags  output  4  head flags {N,Z,V,C}.
- res_tag  output  8  head {op,op1}.
- psw  output  4  {N,Z,V,C} of last accepted result.
- sticky_v  output  1  overflow seen since last clear.
- clr_sticky  input  1  clears sticky_v.
- count  output  AW+1  occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Reset (async, rst=1): rptr=wptr=0, count=0, psw=0, sticky_v=0, storage cleared to 0. Resulting outputs: out_valid=0, in_ready=1, empty=1, full=0, res_* = 0.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = !full. There is no bypass when full: a simultaneous pop on a full FIFO does not enable a push in the same cycle.
- First-word fall-through read path:
  - out_valid = !empty.
  - res_* driven combinationally from mem[rptr].
  - Latency: an entry pushed in cycle t is visible at the output in cycle t+1.
- Entry formation on push:
  - res_hi = alu_out0 if alu_op==0011, else 0.
  - Flag masking: for alu_op 0001 or 0010, stored V=0 and C=0; N and Z are stored as given.
  - All other op classes store the flags unmasked.
- Pointers wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Push while full cannot occur (in_ready=0); in_valid is ignored.
- Pop while empty cannot occur; out_ready is ignored.
- PSW: on each push, psw <= stored (masked) flags of that entry, visible the next cycle. PSW is unchanged on cycles with no push.
- sticky_v:
  - Set on a push whose stored V=1.
  - Cleared by clr_sticky otherwise.
  - Set wins over a simultaneous clear.
- Reset asserted mid-operation discards all queued entries immediately (asynchronous).
- Inputs are sampled only on push cycles; the ALU may change its inputs freely otherwise.

Test Plan:
- Reset, then 4 pushes with out_ready=0 -> full=1, in_ready=0, count=4. A 5th in_valid is dropped. Then pops return entries in push order, and empty=1 after the 4th.
- Push add result alu_out=FFFE0000, alu_op=0000, N=1, V=1, C=0, Z=0 -> res_flags=1010, psw=1010 next cycle, sticky_v=1. Apply clr_sticky with no push -> sticky_v=0.
- Push logic XOR (alu_op=0010, alu_op1=0010) with alu_c=1, alu_v=1, alu_out=01010000, alu_out0=DEADBEEF -> res_flags V=C=0, res_hi=00000000, res_tag=22.
- Push multiply (alu_op=0011), alu_out=00000000, alu_out0=00000002, Z=1 -> res_lo=00000000, res_hi=00000002, res_flags=0100.
- Count=2, then simultaneous push and pop -> count stays 2, head advances, and the new entry lands at the wrapped wptr after more than DEPTH total pushes.
- With 3 entries queued, assert rst asynchronously mid-cycle -> out_valid=0, count=0, psw=0 immediately.
